// File: rtl/ysyx_25040105_mem_arbiter.sv
// ysyx_25040105_mem_arbiter
//
// Shares the single memory port between the instruction-fetch unit (IFU,
// read-only) and the load/store unit (LSU, read/write). One transaction is
// outstanding at a time. Ties are broken round-robin, and addresses are
// word-aligned on the way out. Every memory access is guarded by a response
// timeout. Sub-word handling stays in the LSU: only aligned words and the
// byte mask pass through here.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   ifu_req_*         IFU request: valid/ready handshake, byte address
//   ifu_resp_*        IFU response: one-cycle valid pulse, read word, error
//   lsu_req_*         LSU request: valid/ready, address, wen, wdata, wmask
//   lsu_resp_*        LSU response: one-cycle valid pulse, read word, error
//   mem_req_*         memory request: valid/ready, aligned address, wen,
//                     wdata, wmask
//   mem_resp_*        memory response: valid, read word
//
// Parameter
//   TIMEOUT           cycles spent in WAIT without a response before the
//                     error response is produced (1..255)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; grant one requester and latch its request
// ISSUE | mem_req_valid high with the latched fields until mem_req_ready
// WAIT  | request accepted; wait for mem_resp_valid or the timeout
// RESP  | owner's resp_valid high for one cycle with registered rdata/err

module ysyx_25040105_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic       OWNER_IFU = 1'b0;
  localparam logic       OWNER_LSU = 1'b1;
  localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT - 1);

  state_t      state;
  logic        owner;
  logic        last_owner;
  logic [31:0] addr_q;
  logic        wen_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic [7:0]  cnt;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        mem_req_valid_q;
  logic        ifu_resp_q;
  logic        lsu_resp_q;

  logic        grant_ifu;
  logic        grant_lsu;
  logic        in_idle;

  // The IFU wins unless the LSU is also asking and the IFU went last.
  assign grant_ifu = ifu_req_valid & (~lsu_req_valid | (last_owner == OWNER_LSU));
  assign grant_lsu = lsu_req_valid & ~grant_ifu;
  assign in_idle   = (state == S_IDLE);

  assign ifu_req_ready = in_idle & grant_ifu;
  assign lsu_req_ready = in_idle & grant_lsu;

  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = addr_q & 32'hFFFF_FFFC;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  // rdata/err are shared; each is only meaningful under its own resp_valid.
  assign ifu_resp_valid = ifu_resp_q;
  assign ifu_rdata      = rdata_q;
  assign ifu_err        = err_q;
  assign lsu_resp_valid = lsu_resp_q;
  assign lsu_rdata      = rdata_q;
  assign lsu_err        = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      owner           <= OWNER_IFU;
      last_owner      <= OWNER_LSU;
      addr_q          <= 32'h0;
      wen_q           <= 1'b0;
      wdata_q         <= 32'h0;
      wmask_q         <= 4'h0;
      cnt             <= 8'h0;
      err_q           <= 1'b0;
      rdata_q         <= 32'h0;
      mem_req_valid_q <= 1'b0;
      ifu_resp_q      <= 1'b0;
      lsu_resp_q      <= 1'b0;
    end else begin
      ifu_resp_q <= 1'b0;
      lsu_resp_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (grant_ifu) begin
            owner      <= OWNER_IFU;
            last_owner <= OWNER_IFU;
            addr_q     <= ifu_addr;
            wen_q      <= 1'b0;
            wdata_q    <= 32'h0;
            wmask_q    <= 4'h0;
            // A misaligned fetch is answered locally; memory never sees it.
            if (ifu_addr[1:0] != 2'b00) begin
              err_q      <= 1'b1;
              rdata_q    <= 32'h0;
              ifu_resp_q <= 1'b1;
              state      <= S_RESP;
            end else begin
              mem_req_valid_q <= 1'b1;
              state           <= S_ISSUE;
            end
          end else if (grant_lsu) begin
            owner           <= OWNER_LSU;
            last_owner      <= OWNER_LSU;
            addr_q          <= lsu_addr;
            wen_q           <= lsu_wen;
            wdata_q         <= lsu_wdata;
            wmask_q         <= lsu_wen ? lsu_wmask : 4'h0;
            mem_req_valid_q <= 1'b1;
            state           <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            cnt             <= 8'h0;
            state           <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (mem_resp_valid) begin
            rdata_q    <= wen_q ? 32'h0 : mem_rdata;
            err_q      <= 1'b0;
            ifu_resp_q <= (owner == OWNER_IFU);
            lsu_resp_q <= (owner == OWNER_LSU);
            state      <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            // Last WAIT cycle: the response lands TIMEOUT+1 cycles after
            // the mem_req_ready cycle.
            rdata_q    <= 32'h0;
            err_q      <= 1'b1;
            ifu_resp_q <= (owner == OWNER_IFU);
            lsu_resp_q <= (owner == OWNER_LSU);
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 8'h1;
          end
        end

        S_RESP: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040105_mem_arbiter.sv
// Directed bench for ysyx_25040105_mem_arbiter, built with TIMEOUT=4.
// Inputs change 1-2 time units after the rising edge, and outputs are
// checked at that point, well away from the next edge. The memory side is
// a tiny model: mem_req_ready is driven directly, and when auto_resp is set
// a response follows one cycle after each accepted request.

module tb_ysyx_25040105_mem_arbiter;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        ifu_err;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  logic        auto_resp;
  logic [31:0] resp_data;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_25040105_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_rdata      (ifu_rdata),
    .ifu_err        (ifu_err),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_rdata      (lsu_rdata),
    .lsu_err        (lsu_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; the memory model answers the request accepted last cycle.
  task automatic step();
    logic hs;
    hs = mem_req_valid & mem_req_ready;
    @(posedge clk);
    #1;
    mem_resp_valid = auto_resp & hs;
    mem_rdata      = resp_data;
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    ifu_req_valid  = 1'b0;
    ifu_addr       = 32'h0;
    lsu_req_valid  = 1'b0;
    lsu_addr       = 32'h0;
    lsu_wen        = 1'b0;
    lsu_wdata      = 32'h0;
    lsu_wmask      = 4'h0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'h0;
    auto_resp      = 1'b1;
    resp_data      = 32'h0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // ---- reset state ----
    chk("rst_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("rst_ifu_resp_valid", {31'h0, ifu_resp_valid}, 32'h0);
    chk("rst_lsu_resp_valid", {31'h0, lsu_resp_valid}, 32'h0);
    chk("rst_ifu_err", {31'h0, ifu_err}, 32'h0);
    chk("rst_lsu_err", {31'h0, lsu_err}, 32'h0);
    chk("rst_ifu_rdata", ifu_rdata, 32'h0);
    chk("rst_lsu_rdata", lsu_rdata, 32'h0);
    chk("rst_ready_idle", {30'h0, ifu_req_ready, lsu_req_ready}, 32'h0);

    // ---- both requesting continuously: IFU, LSU, IFU, LSU every 4 cycles ----
    resp_data     = 32'hA5A5_0001;
    ifu_addr      = 32'h8000_0100;
    lsu_addr      = 32'h8000_0200;
    lsu_wen       = 1'b0;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #1;
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("rr_ifu_ready_c%0d", c), {31'h0, ifu_req_ready}, {31'h0, (c % 8) == 0});
      chk($sformatf("rr_lsu_ready_c%0d", c), {31'h0, lsu_req_ready}, {31'h0, (c % 8) == 4});
      chk($sformatf("rr_ifu_resp_c%0d", c), {31'h0, ifu_resp_valid}, {31'h0, (c % 8) == 3});
      chk($sformatf("rr_lsu_resp_c%0d", c), {31'h0, lsu_resp_valid}, {31'h0, (c % 8) == 7});
      if ((c % 4) == 3)
        chk($sformatf("rr_rdata_c%0d", c), ifu_rdata, 32'hA5A5_0001);
      step();
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    step();

    // ---- single LSU write at a misaligned byte address ----
    resp_data     = 32'hDEAD_BEEF;
    lsu_addr      = 32'h8000_0006;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'h1234_0000;
    lsu_wmask     = 4'b1100;
    lsu_req_valid = 1'b1;
    #1;
    chk("wr_lsu_ready", {31'h0, lsu_req_ready}, 32'h1);
    chk("wr_ifu_ready", {31'h0, ifu_req_ready}, 32'h0);
    step();
    lsu_req_valid = 1'b0;
    chk("wr_mem_valid", {31'h0, mem_req_valid}, 32'h1);
    chk("wr_mem_addr", mem_addr, 32'h8000_0004);
    chk("wr_mem_wen", {31'h0, mem_wen}, 32'h1);
    chk("wr_mem_wmask", {28'h0, mem_wmask}, 32'hC);
    chk("wr_mem_wdata", mem_wdata, 32'h1234_0000);
    step();
    chk("wr_wait_no_req", {31'h0, mem_req_valid}, 32'h0);
    chk("wr_wait_no_resp", {31'h0, lsu_resp_valid}, 32'h0);
    step();
    chk("wr_resp_valid", {31'h0, lsu_resp_valid}, 32'h1);
    chk("wr_resp_rdata", lsu_rdata, 32'h0);
    chk("wr_resp_err", {31'h0, lsu_err}, 32'h0);
    chk("wr_resp_ifu", {31'h0, ifu_resp_valid}, 32'h0);
    step();
    chk("wr_resp_pulse", {31'h0, lsu_resp_valid}, 32'h0);

    // ---- IFU read with mem_req_ready held low for 5 cycles ----
    resp_data     = 32'h0010_0073;
    mem_req_ready = 1'b0;
    ifu_addr      = 32'h8000_0000;
    ifu_req_valid = 1'b1;
    #1;
    chk("st_ifu_ready", {31'h0, ifu_req_ready}, 32'h1);
    step();
    ifu_req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("st_valid_c%0d", c), {31'h0, mem_req_valid}, 32'h1);
      chk($sformatf("st_addr_c%0d", c), mem_addr, 32'h8000_0000);
      chk($sformatf("st_wen_c%0d", c), {31'h0, mem_wen}, 32'h0);
      chk($sformatf("st_wmask_c%0d", c), {28'h0, mem_wmask}, 32'h0);
      step();
    end
    mem_req_ready = 1'b1;
    #1;
    chk("st_valid_at_ready", {31'h0, mem_req_valid}, 32'h1);
    step();
    step();
    chk("st_resp_valid", {31'h0, ifu_resp_valid}, 32'h1);
    chk("st_resp_rdata", ifu_rdata, 32'h0010_0073);
    chk("st_resp_err", {31'h0, ifu_err}, 32'h0);
    step();

    // ---- timeout: memory never answers, TIMEOUT=4 ----
    auto_resp     = 1'b0;
    lsu_addr      = 32'h8000_0010;
    lsu_wen       = 1'b0;
    lsu_wmask     = 4'hF;
    lsu_req_valid = 1'b1;
    #1;
    chk("to_lsu_ready", {31'h0, lsu_req_ready}, 32'h1);
    step();
    lsu_req_valid = 1'b0;
    chk("to_mem_wmask_read", {28'h0, mem_wmask}, 32'h0);
    // This cycle is the mem_req_ready cycle; the error lands 5 cycles later.
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("to_quiet_c%0d", c), {31'h0, lsu_resp_valid}, 32'h0);
      step();
    end
    chk("to_resp_valid", {31'h0, lsu_resp_valid}, 32'h1);
    chk("to_resp_err", {31'h0, lsu_err}, 32'h1);
    chk("to_resp_rdata", lsu_rdata, 32'h0);
    step();
    step();
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hBAD0_BAD0;
    step();
    chk("to_late_lsu", {31'h0, lsu_resp_valid}, 32'h0);
    chk("to_late_ifu", {31'h0, ifu_resp_valid}, 32'h0);
    // Next grant behaves normally.
    auto_resp     = 1'b1;
    resp_data     = 32'h7777_1234;
    lsu_addr      = 32'h8000_0020;
    lsu_req_valid = 1'b1;
    #1;
    chk("to_next_ready", {31'h0, lsu_req_ready}, 32'h1);
    step();
    lsu_req_valid = 1'b0;
    chk("to_next_addr", mem_addr, 32'h8000_0020);
    step();
    step();
    chk("to_next_resp", {31'h0, lsu_resp_valid}, 32'h1);
    chk("to_next_rdata", lsu_rdata, 32'h7777_1234);
    chk("to_next_err", {31'h0, lsu_err}, 32'h0);
    step();

    // ---- misaligned IFU fetch ----
    ifu_addr      = 32'h8000_0002;
    ifu_req_valid = 1'b1;
    #1;
    chk("mis_ready", {31'h0, ifu_req_ready}, 32'h1);
    step();
    ifu_req_valid = 1'b0;
    chk("mis_no_mem_req", {31'h0, mem_req_valid}, 32'h0);
    chk("mis_resp_valid", {31'h0, ifu_resp_valid}, 32'h1);
    chk("mis_resp_err", {31'h0, ifu_err}, 32'h1);
    chk("mis_resp_rdata", ifu_rdata, 32'h0);
    step();
    chk("mis_pulse", {31'h0, ifu_resp_valid}, 32'h0);
    chk("mis_no_mem_req2", {31'h0, mem_req_valid}, 32'h0);

    // ---- reset while in WAIT ----
    auto_resp     = 1'b0;
    ifu_addr      = 32'h8000_0040;
    ifu_req_valid = 1'b1;
    step();
    ifu_req_valid = 1'b0;
    chk("rw_issue", {31'h0, mem_req_valid}, 32'h1);
    step();
    // In WAIT now; a response is presented together with reset.
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h5555_AAAA;
    rst_n          = 1'b0;
    #1;
    chk("rw_mem_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("rw_ifu_resp", {31'h0, ifu_resp_valid}, 32'h0);
    chk("rw_lsu_resp", {31'h0, lsu_resp_valid}, 32'h0);
    step();
    mem_resp_valid = 1'b0;
    rst_n          = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rw_no_resp_c%0d", c), {30'h0, ifu_resp_valid, lsu_resp_valid}, 32'h0);
      step();
    end
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #1;
    chk("rw_tie_ifu", {31'h0, ifu_req_ready}, 32'h1);
    chk("rw_tie_lsu", {31'h0, lsu_req_ready}, 32'h0);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
